ttl_bus_rx_fifo: RTL

Clocked receive end for the shared 8-bit tri-state data bus. The bus is driven by the octal enabled buffers (both enables active-LOW, outputs Hi-Z when disabled).
- Captures the bus value on a load strobe into a small show-ahead FIFO.
- Presents the head entry to a consumer with a valid/ready handshake.
- Flags overflow.
- Sits between the bus and the consuming register or ALU input, replacing a bare '574-style capture latch.

---
 rtl/ttl_bus_pkg.sv | 18 +
 rtl/ttl_rx_fifo_core.sv | 70 +++++++
 rtl/ttl_bus_rx_fifo.sv | 77 +++++++
 3 files changed

// File: rtl/ttl_bus_pkg.sv
// Shared constants and helpers for the bus receive path.
package ttl_bus_pkg;

    localparam int BUS_WIDTH = 8;

    // Ceiling log2 for elaboration-time sizing of pointers and counters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_rx_fifo_core.sv
// Show-ahead FIFO storage: circular buffer, pointers, occupancy and a
// registered head-of-queue view. Push/pop arrive already qualified.
module ttl_rx_fifo_core
    import ttl_bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_next;

    // Next read pointer and occupancy; simultaneous push+pop leaves count unchanged.
    always_comb begin
        rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Entry storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is tracked by count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
        end
    end

    // Head register: loads the entry that will be at the head after this edge.
    // When that slot is being written now, take din directly. When the FIFO
    // goes empty the last head value is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (count_next != '0) begin
            dout <= (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/ttl_bus_rx_fifo.sv
// Receive end of the shared tri-state bus: captures D on a load strobe into a
// show-ahead FIFO, hands the head to a consumer via VALID/RDY and flags overflow.
module ttl_bus_rx_fifo
    import ttl_bus_pkg::*;
#(
    parameter int WIDTH     = BUS_WIDTH,
    parameter int DEPTH     = 4,
    parameter int EDGE_MODE = 1,
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             CLR_bar,
    input  logic [WIDTH-1:0] D,
    input  logic             LD_bar,
    input  logic             RDY,
    input  logic             OVF_CLR_bar,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             FULL,
    output logic [CW-1:0]    COUNT,
    output logic             OVF
);

    logic ld_prev;
    logic push_req;
    logic pop;
    logic push_acc;
    logic ovf_set;

    // Push request qualification, accept/reject against occupancy, and output decode.
    always_comb begin
        if (EDGE_MODE != 0) begin
            push_req = !LD_bar && ld_prev;
        end else begin
            push_req = !LD_bar;
        end
        VALID    = (COUNT != '0);
        FULL     = (COUNT == CW'(DEPTH));
        pop      = RDY && VALID;
        push_acc = push_req && (!FULL || pop);
        ovf_set  = push_req && FULL && !pop;
    end

    // Strobe history idles high so a strobe already low at release still counts as an edge.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            ld_prev <= 1'b1;
        end else begin
            ld_prev <= LD_bar;
        end
    end

    // Sticky overflow; a new overflow beats a clear on the same edge.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            OVF <= 1'b0;
        end else if (ovf_set) begin
            OVF <= 1'b1;
        end else if (!OVF_CLR_bar) begin
            OVF <= 1'b0;
        end
    end

    ttl_rx_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (CLK),
        .rst_n (CLR_bar),
        .push  (push_acc),
        .pop   (pop),
        .din   (D),
        .dout  (Q),
        .count (COUNT)
    );

endmodule
